lsu: RTL and testbench

Load/store unit for the single-cycle RV32I core. It sits directly downstream of the ALU: it takes the ALU result as the effective address, the second register operand as store data, and the decoded funct3. It runs one transaction on a simple request/acknowledge data-memory bus and returns the aligned, sign- or zero-extended load result to register writeback. While a transaction is outstanding it stalls the core.

---
 rtl/lsu_pkg.sv | 28 ++
 rtl/lsu_align.sv | 86 ++++++++
 rtl/lsu.sv | 170 +++++++++++++++++
 tb/tb_lsu.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared constants and types for the RV32I load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] BE_B = 4'b0001;
    localparam logic [3:0] BE_H = 4'b0011;
    localparam logic [3:0] BE_W = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

endpackage : lsu_pkg
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_align
// Description : Byte-lane steering for stores, lane select and extension for
//               loads, and the illegal/misaligned request flag.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]      funct3_i,
    input  logic            we_i,
    input  logic [1:0]      addr_lo_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [2:0]      ld_funct3_i,
    input  logic [1:0]      ld_addr_lo_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [3:0]      be_o,
    output logic [XLEN-1:0] wdata_o,
    output logic [XLEN-1:0] rdata_o,
    output logic            bad_o
);

    logic       w_legal;
    logic       w_misaligned;
    logic [7:0] w_byte;
    logic [15:0] w_half;

    // Issue-side decode: the unsigned variants exist only for loads.
    always_comb begin
        w_legal      = 1'b0;
        w_misaligned = 1'b0;
        be_o         = 4'b0000;
        wdata_o      = wdata_i;
        case (funct3_i)
            F3_B: begin
                w_legal = 1'b1;
                be_o    = BE_B << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            F3_H: begin
                w_legal      = 1'b1;
                w_misaligned = addr_lo_i[0];
                be_o         = BE_H << addr_lo_i;
                wdata_o      = {2{wdata_i[15:0]}};
            end
            F3_W: begin
                w_legal      = 1'b1;
                w_misaligned = |addr_lo_i;
                be_o         = BE_W;
            end
            F3_BU: begin
                w_legal = !we_i;
                be_o    = BE_B << addr_lo_i;
            end
            F3_HU: begin
                w_legal      = !we_i;
                w_misaligned = addr_lo_i[0];
                be_o         = BE_H << addr_lo_i;
            end
            default: begin
                w_legal = 1'b0;
            end
        endcase
        bad_o = !w_legal || w_misaligned;
    end

    always_comb begin
        case (ld_addr_lo_i)
            2'd0:    w_byte = rdata_i[7:0];
            2'd1:    w_byte = rdata_i[15:8];
            2'd2:    w_byte = rdata_i[23:16];
            default: w_byte = rdata_i[31:24];
        endcase
        w_half = ld_addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (ld_funct3_i)
            F3_B:    rdata_o = {{24{w_byte[7]}}, w_byte};
            F3_H:    rdata_o = {{16{w_half[15]}}, w_half};
            F3_BU:   rdata_o = {24'd0, w_byte};
            F3_HU:   rdata_o = {16'd0, w_half};
            default: rdata_o = rdata_i;
        endcase
    end

endmodule : lsu_align
`default_nettype wire

// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
// Module      : lsu
// Description : RV32I load/store unit - request/ack bus FSM with timeout,
//               registered bus and response outputs, core stall.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu
    import lsu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic             req_we,
    input  logic [2:0]       req_funct3,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             stall,
    output logic             resp_valid,
    output logic [WIDTH-1:0] resp_rdata,
    output logic             resp_err,
    output logic             mem_req,
    output logic             mem_we,
    output logic [3:0]       mem_be,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ack
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    lsu_state_t       state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             mem_req_q, mem_req_d;
    logic             mem_we_q, mem_we_d;
    logic [3:0]       mem_be_q, mem_be_d;
    logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic             resp_valid_q, resp_valid_d;
    logic [WIDTH-1:0] resp_rdata_q, resp_rdata_d;
    logic             resp_err_q, resp_err_d;
    logic [2:0]       f3_q, f3_d;
    logic [1:0]       alo_q, alo_d;

    logic [3:0]       w_be;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_rdata;
    logic             w_bad;

    // Load extraction uses the latched funct3/lane so the result does not
    // depend on the core keeping the request stable.
    lsu_align u_align (
        .funct3_i     (req_funct3),
        .we_i         (req_we),
        .addr_lo_i    (req_addr[1:0]),
        .wdata_i      (req_wdata),
        .ld_funct3_i  (f3_q),
        .ld_addr_lo_i (alo_q),
        .rdata_i      (mem_rdata),
        .be_o         (w_be),
        .wdata_o      (w_wdata),
        .rdata_o      (w_rdata),
        .bad_o        (w_bad)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 8'd0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_be_q     <= 4'b0000;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            f3_q         <= 3'd0;
            alo_q        <= 2'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_be_q     <= mem_be_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            f3_q         <= f3_d;
            alo_q        <= alo_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_be_d     = mem_be_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;
        f3_d         = f3_q;
        alo_d        = alo_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (w_bad) begin
                        state_d      = DONE;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else begin
                        state_d     = WAIT;
                        cnt_d       = 8'd0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = req_we;
                        mem_be_d    = w_be;
                        mem_addr_d  = {req_addr[WIDTH-1:2], 2'b00};
                        mem_wdata_d = w_wdata;
                        f3_d        = req_funct3;
                        alo_d       = req_addr[1:0];
                    end
                end
            end
            WAIT: begin
                if (mem_ack) begin
                    state_d      = DONE;
                    mem_req_d    = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = mem_we_q ? '0 : w_rdata;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    // The current cycle is the TIMEOUT-th WAIT cycle.
                    if (cnt_q == CNT_LAST) begin
                        state_d      = DONE;
                        mem_req_d    = 1'b0;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign stall      = req_valid && !resp_valid_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_be     = mem_be_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule : lsu
`default_nettype wire

// File: tb/tb_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu
// Description : Directed self-checking bench for the load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int n_cmp = 0;
    int n_bad = 0;

    // Observations captured by xact
    int          o_lat;
    int          o_req_cyc;
    int          o_stall_cyc;
    logic        o_we;
    logic [3:0]  o_be;
    logic [31:0] o_addr;
    logic [31:0] o_wdata;
    logic [31:0] o_rdata;
    logic        o_err;
    logic        o_stable;

    lsu #(.WIDTH(32), .TIMEOUT(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .stall      (stall),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Issues one request in cycle C0 and runs until resp_valid (bounded).
    // ack_after = number of un-acked WAIT cycles before ack; -1 = never ack.
    task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata,
                        input int ack_after);
        int  waits;
        bit  got;
        bit  first;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        waits = 0; got = 0; first = 1;
        o_lat = -1; o_req_cyc = 0; o_stall_cyc = 0; o_stable = 1'b1;
        o_we = 1'bx; o_be = 'x; o_addr = 'x; o_wdata = 'x; o_rdata = 'x; o_err = 1'bx;
        for (int c = 0; c < 64 && !got; c++) begin
            mem_ack   = (ack_after >= 0) && mem_req && (waits == ack_after);
            mem_rdata = rdata;
            @(negedge clk);
            if (stall) o_stall_cyc++;
            if (mem_req) begin
                o_req_cyc++;
                if (first) begin
                    o_we = mem_we; o_be = mem_be; o_addr = mem_addr; o_wdata = mem_wdata;
                    first = 0;
                end else if (mem_we !== o_we || mem_be !== o_be ||
                             mem_addr !== o_addr || mem_wdata !== o_wdata) begin
                    o_stable = 1'b0;
                end
                if (!mem_ack) waits++;
            end
            if (resp_valid) begin
                got     = 1;
                o_lat   = c;
                o_rdata = resp_rdata;
                o_err   = resp_err;
            end
            next_cycle();
        end
        req_valid = 1'b0;
        mem_ack   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0; mem_rdata = 32'd0; mem_ack = 1'b0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("rst_mem_req",   {31'd0, mem_req},    32'd0);
        check("rst_mem_we",    {31'd0, mem_we},     32'd0);
        check("rst_mem_be",    {28'd0, mem_be},     32'd0);
        check("rst_mem_addr",  mem_addr,            32'd0);
        check("rst_mem_wdata", mem_wdata,           32'd0);
        check("rst_resp",      {30'd0, resp_valid, resp_err}, 32'd0);
        check("rst_rdata",     resp_rdata,          32'd0);
        check("rst_stall",     {31'd0, stall},      32'd0);
        next_cycle();
        rst = 1'b0;
        next_cycle();

        // LW 0x100, ack in first WAIT cycle
        xact(1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0);
        check("lw_lat",   o_lat,     32'd2);
        check("lw_reqc",  o_req_cyc, 32'd1);
        check("lw_addr",  o_addr,    32'h0000_0100);
        check("lw_be",    {28'd0, o_be}, 32'hF);
        check("lw_we",    {31'd0, o_we}, 32'd0);
        check("lw_rdata", o_rdata,   32'hDEAD_BEEF);
        check("lw_err",   {31'd0, o_err}, 32'd0);
        @(negedge clk);
        check("lw_pulse", {31'd0, resp_valid}, 32'd0);
        next_cycle();

        // Byte/halfword loads with sign and zero extension
        xact(1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_FF7F, 0);
        check("lb_103",     o_rdata, 32'hFFFF_FF80);
        check("lb_103_be",  {28'd0, o_be}, 32'h8);
        check("lb_103_adr", o_addr, 32'h0000_0100);
        xact(1'b0, 3'b100, 32'h0000_0103, 32'h0, 32'h80FF_FF7F, 0);
        check("lbu_103",    o_rdata, 32'h0000_0080);
        xact(1'b0, 3'b000, 32'h0000_0100, 32'h0, 32'h80FF_FF7F, 1);
        check("lb_100",     o_rdata, 32'h0000_007F);
        check("lb_100_lat", o_lat,   32'd3);
        xact(1'b0, 3'b001, 32'h0000_0102, 32'h0, 32'h80FF_FF7F, 0);
        check("lh_102",     o_rdata, 32'hFFFF_80FF);
        check("lh_102_be",  {28'd0, o_be}, 32'hC);
        xact(1'b0, 3'b101, 32'h0000_0100, 32'h0, 32'h80FF_FF7F, 0);
        check("lhu_100",    o_rdata, 32'h0000_FF7F);
        check("lhu_100_be", {28'd0, o_be}, 32'h3);

        // SH 0x202, ack after 3 wait cycles
        xact(1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 32'hFFFF_FFFF, 3);
        check("sh_lat",    o_lat,       32'd5);
        check("sh_stall",  o_stall_cyc, 32'd5);
        check("sh_reqc",   o_req_cyc,   32'd4);
        check("sh_we",     {31'd0, o_we}, 32'd1);
        check("sh_be",     {28'd0, o_be}, 32'hC);
        check("sh_wdata",  o_wdata,     32'hABCD_ABCD);
        check("sh_addr",   o_addr,      32'h0000_0200);
        check("sh_stable", {31'd0, o_stable}, 32'd1);
        check("sh_rdata",  o_rdata,     32'd0);
        check("sh_err",    {31'd0, o_err}, 32'd0);

        // SB lane 1
        xact(1'b1, 3'b000, 32'h0000_0301, 32'h0000_005A, 32'h0, 0);
        check("sb_be",    {28'd0, o_be}, 32'h2);
        check("sb_wdata", o_wdata, 32'h5A5A_5A5A);

        // Errors at issue
        xact(1'b0, 3'b010, 32'h0000_0101, 32'h0, 32'h1111_1111, 0);
        check("lw_mis_lat",  o_lat,     32'd1);
        check("lw_mis_err",  {31'd0, o_err}, 32'd1);
        check("lw_mis_req",  o_req_cyc, 32'd0);
        check("lw_mis_data", o_rdata,   32'd0);
        xact(1'b0, 3'b011, 32'h0000_0100, 32'h0, 32'h1111_1111, 0);
        check("f3_011_lat",  o_lat,     32'd1);
        check("f3_011_err",  {31'd0, o_err}, 32'd1);
        check("f3_011_req",  o_req_cyc, 32'd0);
        xact(1'b1, 3'b100, 32'h0000_0100, 32'h0, 32'h0, 0);
        check("sbu_err",     {31'd0, o_err}, 32'd1);
        check("sbu_req",     o_req_cyc, 32'd0);
        xact(1'b1, 3'b001, 32'h0000_0203, 32'h0, 32'h0, 0);
        check("sh_mis_err",  {31'd0, o_err}, 32'd1);

        // Timeout, then a late ack that must be ignored
        xact(1'b0, 3'b010, 32'h0000_0400, 32'h0, 32'h2222_2222, -1);
        check("to_reqc",   o_req_cyc, 32'd16);
        check("to_lat",    o_lat,     32'd17);
        check("to_err",    {31'd0, o_err}, 32'd1);
        check("to_rdata",  o_rdata,   32'd0);
        check("to_stable", {31'd0, o_stable}, 32'd1);
        mem_ack = 1'b1;
        mem_rdata = 32'h3333_3333;
        @(negedge clk);
        check("late_ack_valid", {31'd0, resp_valid}, 32'd0);
        next_cycle();
        @(negedge clk);
        check("late_ack_valid2", {31'd0, resp_valid}, 32'd0);
        check("late_ack_req",    {31'd0, mem_req}, 32'd0);
        next_cycle();
        mem_ack = 1'b0;

        // Reset during WAIT
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010;
        req_addr = 32'h0000_0300; req_wdata = 32'h0;
        next_cycle();
        @(negedge clk);
        check("rw_req_on", {31'd0, mem_req}, 32'd1);
        next_cycle();
        rst = 1'b1;
        next_cycle();
        @(negedge clk);
        check("rw_req_off", {31'd0, mem_req}, 32'd0);
        check("rw_valid",   {31'd0, resp_valid}, 32'd0);
        check("rw_stall",   {31'd0, stall}, 32'd1);
        next_cycle();
        rst = 1'b0;
        req_valid = 1'b0;
        next_cycle();
        xact(1'b0, 3'b010, 32'h0000_0300, 32'h0, 32'h1357_9BDF, 1);
        check("rw_lw_lat",   o_lat,   32'd3);
        check("rw_lw_rdata", o_rdata, 32'h1357_9BDF);
        check("rw_lw_err",   {31'd0, o_err}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_lsu
`default_nettype wire
